mm_operand_loader: RTL and testbench

MM_OPERAND_LOADER -- requirements
Module: mm_operand_loader

---
 rtl/mm_loader_pkg.sv | 21 ++
 rtl/mm_tile_bank.sv | 19 +
 rtl/mm_operand_loader.sv | 73 +++++++
 tb/tb_mm_operand_loader.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mm_loader_pkg.sv
// mm_loader_pkg: shared tile geometry helpers and default geometry for the operand loader
package mm_loader_pkg;
  localparam int DEF_ROW_NUM = 8;
  localparam int DEF_COL_NUM = 8;
  localparam int DEF_LENGTH = 8;
  function automatic int mat_elems(input int rows, input int len);
    return rows * len;
  endfunction
  function automatic int fil_elems(input int len, input int cols);
    return len * cols;
  endfunction
  function automatic int tile_beats(input int rows, input int cols, input int len);
    return mat_elems(rows, len) + fil_elems(len, cols);
  endfunction
  function automatic int cnt_width(input int beats);
    return beats > 1 ? $clog2(beats) : 1;
  endfunction
  localparam int MAT_ELEMS = mat_elems(DEF_ROW_NUM, DEF_LENGTH);
  localparam int FIL_ELEMS = fil_elems(DEF_LENGTH, DEF_COL_NUM);
  localparam int TILE = MAT_ELEMS + FIL_ELEMS;
endpackage

// File: rtl/mm_tile_bank.sv
// mm_tile_bank: one tile of storage, written one slot per beat and read back full-width
module mm_tile_bank
  import mm_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SLOTS = TILE,
  parameter int AW = cnt_width(SLOTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [AW-1:0]               addr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  output logic [DATA_WIDTH*SLOTS-1:0] data
);
  always_ff @(posedge clk)
    if (reset) data <= '0;
    else if (we) data[addr*DATA_WIDTH +: DATA_WIDTH] <= wdata;
endmodule

// File: rtl/mm_operand_loader.sv
// mm_operand_loader: ping-pong tile assembler feeding mat/fil operands to a GEMM array
module mm_operand_loader
  import mm_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM = 8,
  parameter int COL_NUM = 8,
  parameter int LENGTH = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH*ROW_NUM*LENGTH-1:0] mat,
  output logic [DATA_WIDTH*LENGTH*COL_NUM-1:0] fil,
  output logic                                 err
);
  localparam int MAT_N = mat_elems(ROW_NUM, LENGTH);
  localparam int FIL_N = fil_elems(LENGTH, COL_NUM);
  localparam int TILE_N = tile_beats(ROW_NUM, COL_NUM, LENGTH);
  localparam int CW = cnt_width(TILE_N);
  logic [CW-1:0] cnt;
  logic wr, rd, acc, at_end;
  logic [1:0] full;
  logic [DATA_WIDTH*TILE_N-1:0] bank_data [2];
  logic [DATA_WIDTH*TILE_N-1:0] tile;
  assign in_ready = !full[wr];
  assign out_valid = full[rd];
  assign acc = in_valid && in_ready;
  assign at_end = cnt == CW'(TILE_N - 1);
  assign tile = rd ? bank_data[1] : bank_data[0];
  assign mat = tile[DATA_WIDTH*MAT_N-1:0];
  assign fil = tile[DATA_WIDTH*TILE_N-1 -: DATA_WIDTH*FIL_N];
  genvar b;
  for (b = 0; b < 2; b++) begin : g_bank
    mm_tile_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .SLOTS(TILE_N)
    ) u_bank (
      .clk(clk),
      .reset(reset),
      .we(acc && wr == 1'(b)),
      .addr(cnt),
      .wdata(in_data),
      .data(bank_data[b])
    );
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      wr <= 1'b0;
      rd <= 1'b0;
      full <= '0;
      err <= 1'b0;
    end else begin
      if (acc) begin
        cnt <= (at_end || in_last) ? '0 : cnt + 1'b1;
        if (at_end) begin
          full[wr] <= 1'b1;
          wr <= !wr;
        end
        if (at_end != in_last) err <= 1'b1;
      end
      if (out_valid && out_ready) begin
        full[rd] <= 1'b0;
        rd <= !rd;
      end
    end
endmodule

// File: tb/tb_mm_operand_loader.sv
// tb_mm_operand_loader: directed and random checks of the loader against a tile-queue model
module tb_mm_operand_loader;
  localparam int T = 128;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, out_valid, err;
  logic [511:0] mat, fil;
  int checks = 0;
  int failures = 0;
  logic [1023:0] q[$];
  logic [1023:0] cur = '0;
  int m_cnt = 0;
  bit m_err = 1'b0;
  int pulses, last_pulse, gap_bad, drops;
  always #5 clk = ~clk;
  mm_operand_loader dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mat(mat),
    .fil(fil),
    .err(err)
  );
  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_model();
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    chk("err", err, m_err);
    if (q.size() > 0) chk("tile", {fil, mat}, q[0]);
  endtask
  task automatic model_edge(input logic v, input logic [7:0] d, input logic l, input logic r);
    bit cons, acc;
    cons = r && q.size() > 0;
    acc = v && q.size() < 2;
    if (cons) void'(q.pop_front());
    if (acc) begin
      cur[m_cnt*8 +: 8] = d;
      if (m_cnt == T - 1) begin
        q.push_back(cur);
        m_cnt = 0;
        if (!l) m_err = 1'b1;
      end else if (l) begin
        m_cnt = 0;
        m_err = 1'b1;
      end else m_cnt++;
    end
  endtask
  task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic r);
    in_valid = v;
    in_data = d;
    in_last = l;
    out_ready = r;
    #1;
    check_model();
    @(posedge clk);
    model_edge(v, d, l, r);
    @(negedge clk);
  endtask
  task automatic do_reset(input logic v);
    reset = 1'b1;
    in_valid = v;
    in_data = 8'hAA;
    in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    q.delete();
    m_cnt = 0;
    m_err = 1'b0;
    cur = '0;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_mat", mat, '0);
    chk("rst_fil", fil, '0);
  endtask
  task automatic feed(input int n, input int base, input int last_at, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b1, 8'(base + i), i == last_at, r);
  endtask
  initial begin
    @(negedge clk);
    do_reset(1'b0);
    feed(T, 0, T - 1, 1'b0);
    chk("s1_valid", out_valid, 1'b1);
    chk("s1_mat_first", mat[7:0], 8'd0);
    chk("s1_mat_last", mat[511:504], 8'd63);
    chk("s1_fil_first", fil[7:0], 8'd64);
    chk("s1_fil_last", fil[511:504], 8'd127);
    chk("s1_err", err, 1'b0);
    feed(T, T, T - 1, 1'b0);
    chk("s2_stall", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'd0, 1'b0, 1'b0);
    cyc(1'b1, 8'd0, 1'b0, 1'b1);
    chk("s2_ready_back", in_ready, 1'b1);
    chk("s2_mat_first", mat[7:0], 8'd128);
    do_reset(1'b0);
    feed(11, 0, 10, 1'b0);
    chk("s3_err", err, 1'b1);
    chk("s3_no_valid", out_valid, 1'b0);
    feed(T, 11, T - 1, 1'b0);
    chk("s3_valid", out_valid, 1'b1);
    chk("s3_mat_first", mat[7:0], 8'd11);
    do_reset(1'b0);
    feed(T, 0, -1, 1'b0);
    chk("s4_valid", out_valid, 1'b1);
    chk("s4_err", err, 1'b1);
    do_reset(1'b0);
    feed(50, 0, -1, 1'b0);
    do_reset(1'b1);
    feed(T, 0, T - 1, 1'b0);
    chk("s5_valid", out_valid, 1'b1);
    chk("s5_mat_first", mat[7:0], 8'd0);
    chk("s5_fil_last", fil[511:504], 8'd127);
    do_reset(1'b0);
    pulses = 0;
    last_pulse = -1;
    gap_bad = 0;
    drops = 0;
    for (int i = 0; i < 4 * T; i++) begin
      cyc(1'b1, 8'(i), (i % T) == T - 1, 1'b1);
      if (!in_ready) drops++;
      if (out_valid) begin
        if (last_pulse >= 0 && i - last_pulse != T) gap_bad++;
        last_pulse = i;
        pulses++;
      end
    end
    chk("s6_pulses", pulses, 4);
    chk("s6_gaps", gap_bad, 0);
    chk("s6_drops", drops, 0);
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 699) == 0) do_reset(1'($urandom_range(0, 1)));
      cyc($urandom_range(0, 3) != 0, 8'($urandom), (m_cnt == T - 1) ^ ($urandom_range(0, 63) == 0), $urandom_range(0, 2) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
